par2ser_lanes: RTL and testbench

PAR2SER_LANES -- requirements
Module: par2ser_lanes

---
 rtl/par2ser_lanes_pkg.sv | 21 ++
 rtl/par2ser_lanes_counter.sv | 47 ++++
 rtl/par2ser_lanes.sv | 150 +++++++++++++++
 tb/tb_par2ser_lanes.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/par2ser_lanes_pkg.sv
// -----------------------------------------------------------------------------
// par2ser_lanes_pkg
// Shared helpers for the parallel-to-serial lane converter.
//   calc_cnt_w   : width of a slice counter for a given word/lane ratio,
//                  never narrower than one bit.
//   cur_action_e : what happens to the active shift slot on a clock edge.
// -----------------------------------------------------------------------------
package par2ser_lanes_pkg;

   function automatic int calc_cnt_w(input int ratio);
      return (ratio > 1) ? $clog2(ratio) : 1;
   endfunction

   typedef enum logic [1:0] {
      SLOT_HOLD      = 2'd0,
      SLOT_LOAD_DIN  = 2'd1,
      SLOT_LOAD_PEND = 2'd2,
      SLOT_DRAIN     = 2'd3
   } cur_action_e;

endpackage

// File: rtl/par2ser_lanes_counter.sv
// -----------------------------------------------------------------------------
// par2ser_lanes_counter
// Modulo-MODULUS up counter with enable; wraps to 0 after MODULUS-1.
// With MODULUS=1 the count is held at 0 and wrap is always high.
// Ports:
//   clk   - rising-edge clock
//   rst_n - asynchronous active-low reset, clears the count
//   en    - advance the count this cycle
//   cnt   - current count
//   wrap  - count is at its terminal value MODULUS-1
// -----------------------------------------------------------------------------
module par2ser_lanes_counter
   import par2ser_lanes_pkg::*;
#(
   parameter int MODULUS = 4,
   parameter int WIDTH   = calc_cnt_w(MODULUS)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   output logic [WIDTH-1:0] cnt,
   output logic             wrap
);

   logic [WIDTH-1:0] cnt_q;
   logic [WIDTH-1:0] cnt_d;

   assign wrap = (cnt_q == WIDTH'(MODULUS - 1));
   assign cnt  = cnt_q;

   // Advance on enable, folding back to zero at the terminal value.
   always_comb begin
      cnt_d = cnt_q;
      if (en) begin
         cnt_d = wrap ? '0 : cnt_q + WIDTH'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/par2ser_lanes.sv
// -----------------------------------------------------------------------------
// par2ser_lanes
// Splits IN_WIDTH-bit words into RATIO = IN_WIDTH/OUT_WIDTH slices of
// OUT_WIDTH bits, one slice per downstream handshake, LSB or MSB slice first.
// Two word slots (active + pending) let the next word stream out with no
// bubble, while din_rdy comes straight from a flop.
// Ports:
//   clk       - rising-edge clock
//   rst_n     - asynchronous active-low reset
//   din       - parallel word from upstream
//   din_vld   - din is valid
//   din_rdy   - block can take din this cycle (registered)
//   dout      - current output slice
//   dout_vld  - dout is valid
//   dout_last - dout is the final slice of its word
//   dout_rdy  - downstream takes dout this cycle
// -----------------------------------------------------------------------------
module par2ser_lanes
   import par2ser_lanes_pkg::*;
#(
   parameter int IN_WIDTH  = 8,
   parameter int OUT_WIDTH = 1,
   parameter int LSB_FIRST = 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [IN_WIDTH-1:0]  din,
   input  logic                 din_vld,
   output logic                 din_rdy,
   output logic [OUT_WIDTH-1:0] dout,
   output logic                 dout_vld,
   output logic                 dout_last,
   input  logic                 dout_rdy
);

   localparam int RATIO = IN_WIDTH / OUT_WIDTH;
   localparam int CNT_W = calc_cnt_w(RATIO);

   if ((IN_WIDTH % OUT_WIDTH) != 0) begin : g_width_check
      $error("par2ser_lanes: IN_WIDTH must be a multiple of OUT_WIDTH");
   end

   logic [IN_WIDTH-1:0] cur_q;
   logic [IN_WIDTH-1:0] cur_d;
   logic                cur_vld_q;
   logic                cur_vld_d;
   logic [IN_WIDTH-1:0] pend_q;
   logic [IN_WIDTH-1:0] pend_d;
   logic                pend_vld_q;
   logic                pend_vld_d;

   logic                wr;
   logic                rd;
   logic [CNT_W-1:0]    cnt;
   logic                cnt_wrap;
   logic [CNT_W-1:0]    slice_idx;
   int                  slice_off;
   cur_action_e         cur_action;

   assign din_rdy   = ~pend_vld_q;
   assign dout_vld  = cur_vld_q;
   assign dout_last = cur_vld_q & cnt_wrap;
   assign wr        = din_vld & din_rdy;
   assign rd        = cur_vld_q & dout_rdy;

   par2ser_lanes_counter #(
      .MODULUS (RATIO),
      .WIDTH   (CNT_W)
   ) counter (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (rd),
      .cnt   (cnt),
      .wrap  (cnt_wrap)
   );

   // MSB-first walks the slices from the top down.
   always_comb begin
      slice_idx = cnt;
      if (LSB_FIRST == 0) begin
         slice_idx = CNT_W'(RATIO - 1) - cnt;
      end
      slice_off = int'(slice_idx) * OUT_WIDTH;
      dout      = cur_q[slice_off +: OUT_WIDTH];
   end

   // Decide the fate of both slots. A finishing word hands over to the
   // pending word first; only with pend empty can din land straight in cur.
   // pend is never full while cur is empty, so a wr with cur idle always
   // goes to cur.
   always_comb begin
      cur_action = SLOT_HOLD;
      pend_d     = pend_q;
      pend_vld_d = pend_vld_q;
      if (rd && dout_last) begin
         if (pend_vld_q) begin
            cur_action = SLOT_LOAD_PEND;
            pend_vld_d = 1'b0;
         end else if (wr) begin
            cur_action = SLOT_LOAD_DIN;
         end else begin
            cur_action = SLOT_DRAIN;
         end
      end else if (wr) begin
         if (!cur_vld_q) begin
            cur_action = SLOT_LOAD_DIN;
         end else begin
            pend_d     = din;
            pend_vld_d = 1'b1;
         end
      end
   end

   always_comb begin
      cur_d     = cur_q;
      cur_vld_d = cur_vld_q;
      case (cur_action)
         SLOT_LOAD_DIN: begin
            cur_d     = din;
            cur_vld_d = 1'b1;
         end
         SLOT_LOAD_PEND: begin
            cur_d     = pend_q;
            cur_vld_d = 1'b1;
         end
         SLOT_DRAIN: begin
            cur_vld_d = 1'b0;
         end
         default: begin
            cur_d     = cur_q;
            cur_vld_d = cur_vld_q;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cur_q      <= '0;
         cur_vld_q  <= 1'b0;
         pend_q     <= '0;
         pend_vld_q <= 1'b0;
      end else begin
         cur_q      <= cur_d;
         cur_vld_q  <= cur_vld_d;
         pend_q     <= pend_d;
         pend_vld_q <= pend_vld_d;
      end
   end

endmodule

// File: tb/tb_par2ser_lanes.sv
// -----------------------------------------------------------------------------
// tb_par2ser_lanes
// Drives an 8->2 LSB-first and an 8->2 MSB-first instance from the same
// inputs, plus an 8->8 instance for the single-slice case.
// -----------------------------------------------------------------------------
module tb_par2ser_lanes;

   logic       clk;
   logic       rst_n;
   logic       din_vld;
   logic [7:0] din;
   logic       dout_rdy;

   logic       din_rdy_l, din_rdy_m;
   logic [1:0] dout_l, dout_m;
   logic       vld_l, vld_m;
   logic       last_l, last_m;

   logic       r1_din_vld;
   logic [7:0] r1_din;
   logic       r1_dout_rdy;
   logic       r1_din_rdy;
   logic [7:0] r1_dout;
   logic       r1_vld;
   logic       r1_last;

   int numChecks = 0;
   int numFails  = 0;

   typedef struct {
      logic       din_vld;
      logic [7:0] din;
      logic       dout_rdy;
      logic       exp_din_rdy;
      logic       exp_vld;
      logic       exp_last;
      logic [1:0] exp_lsb;
      logic [1:0] exp_msb;
   } vec_t;

   vec_t vecs[$];

   par2ser_lanes #(.IN_WIDTH(8), .OUT_WIDTH(2), .LSB_FIRST(1)) dut_lsb (
      .clk(clk), .rst_n(rst_n), .din(din), .din_vld(din_vld), .din_rdy(din_rdy_l),
      .dout(dout_l), .dout_vld(vld_l), .dout_last(last_l), .dout_rdy(dout_rdy)
   );

   par2ser_lanes #(.IN_WIDTH(8), .OUT_WIDTH(2), .LSB_FIRST(0)) dut_msb (
      .clk(clk), .rst_n(rst_n), .din(din), .din_vld(din_vld), .din_rdy(din_rdy_m),
      .dout(dout_m), .dout_vld(vld_m), .dout_last(last_m), .dout_rdy(dout_rdy)
   );

   par2ser_lanes #(.IN_WIDTH(8), .OUT_WIDTH(8), .LSB_FIRST(1)) dut_r1 (
      .clk(clk), .rst_n(rst_n), .din(r1_din), .din_vld(r1_din_vld), .din_rdy(r1_din_rdy),
      .dout(r1_dout), .dout_vld(r1_vld), .dout_last(r1_last), .dout_rdy(r1_dout_rdy)
   );

   // Free-running 10 ns clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Drive the inputs shared by the two 8->2 instances.
   task automatic applyStimulus(input logic vld, input logic [7:0] data, input logic rdy);
      din_vld  = vld;
      din      = data;
      dout_rdy = rdy;
   endtask

   // Compare one observed value against its expectation and keep the tallies.
   task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
      numChecks++;
      if (act !== exp) begin
         numFails++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Check both 8->2 instances for the same control values and their own slices.
   task automatic checkPair(input string tag, input logic exp_rdy, input logic exp_vld,
                            input logic exp_last, input logic [1:0] exp_lsb,
                            input logic [1:0] exp_msb, input logic check_data);
      checkOutput({tag, " din_rdy_lsb"}, 8'(din_rdy_l), 8'(exp_rdy));
      checkOutput({tag, " din_rdy_msb"}, 8'(din_rdy_m), 8'(exp_rdy));
      checkOutput({tag, " vld_lsb"}, 8'(vld_l), 8'(exp_vld));
      checkOutput({tag, " vld_msb"}, 8'(vld_m), 8'(exp_vld));
      checkOutput({tag, " last_lsb"}, 8'(last_l), 8'(exp_last));
      checkOutput({tag, " last_msb"}, 8'(last_m), 8'(exp_last));
      if (check_data) begin
         checkOutput({tag, " dout_lsb"}, 8'(dout_l), 8'(exp_lsb));
         checkOutput({tag, " dout_msb"}, 8'(dout_m), 8'(exp_msb));
      end
   endtask

   // Main sequence: reset state, vector table, mid-word reset, single-slice stream.
   initial begin
      logic [1:0] rst_lsb [4];
      logic [1:0] rst_msb [4];
      logic [7:0] words [4];

      rst_n       = 1'b0;
      r1_din_vld  = 1'b0;
      r1_din      = 8'h00;
      r1_dout_rdy = 1'b0;
      applyStimulus(1'b0, 8'h00, 1'b0);

      // B4 = 10_11_01_00, 5A = 01_01_10_10
      vecs.push_back('{1'b1, 8'hB4, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00});
      vecs.push_back('{1'b1, 8'h5A, 1'b1, 1'b1, 1'b1, 1'b0, 2'b00, 2'b10});
      vecs.push_back('{1'b1, 8'h5A, 1'b1, 1'b0, 1'b1, 1'b0, 2'b01, 2'b11});
      vecs.push_back('{1'b1, 8'h5A, 1'b1, 1'b0, 1'b1, 1'b0, 2'b11, 2'b01});
      vecs.push_back('{1'b1, 8'h5A, 1'b1, 1'b0, 1'b1, 1'b1, 2'b10, 2'b00});
      vecs.push_back('{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 2'b10, 2'b01});
      vecs.push_back('{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 2'b10, 2'b01});
      vecs.push_back('{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 2'b01, 2'b10});
      vecs.push_back('{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1, 2'b01, 2'b10});
      vecs.push_back('{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00});
      // C6 = 11_00_01_10, E1 = 11_10_00_01; stall while E1 arrives, FF refused
      vecs.push_back('{1'b1, 8'hC6, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00});
      vecs.push_back('{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 2'b10, 2'b11});
      vecs.push_back('{1'b1, 8'hE1, 1'b0, 1'b1, 1'b1, 1'b0, 2'b01, 2'b00});
      vecs.push_back('{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 2'b01, 2'b00});
      vecs.push_back('{1'b1, 8'hFF, 1'b0, 1'b0, 1'b1, 1'b0, 2'b01, 2'b00});
      vecs.push_back('{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 2'b01, 2'b00});
      vecs.push_back('{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 2'b00, 2'b01});
      vecs.push_back('{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 2'b11, 2'b10});
      vecs.push_back('{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 2'b01, 2'b11});
      vecs.push_back('{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 2'b00, 2'b10});
      vecs.push_back('{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 2'b10, 2'b00});
      vecs.push_back('{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1, 2'b11, 2'b01});
      vecs.push_back('{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00});
      // 2D = 00_10_11_01, then 87 = 10_00_01_11 loaded directly on last beat
      vecs.push_back('{1'b1, 8'h2D, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00});
      vecs.push_back('{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 2'b01, 2'b00});
      vecs.push_back('{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 2'b11, 2'b10});
      vecs.push_back('{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 2'b10, 2'b11});
      vecs.push_back('{1'b1, 8'h87, 1'b1, 1'b1, 1'b1, 1'b1, 2'b00, 2'b01});
      vecs.push_back('{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 2'b11, 2'b10});
      vecs.push_back('{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 2'b01, 2'b00});
      vecs.push_back('{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 2'b00, 2'b01});
      vecs.push_back('{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1, 2'b10, 2'b11});
      vecs.push_back('{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00});

      // Reset state while rst_n is held low.
      #12;
      checkPair("reset", 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 1'b1);
      checkOutput("reset r1_vld", 8'(r1_vld), 8'h00);
      checkOutput("reset r1_last", 8'(r1_last), 8'h00);
      checkOutput("reset r1_dout", r1_dout, 8'h00);
      checkOutput("reset r1_din_rdy", 8'(r1_din_rdy), 8'h01);

      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      $display("[TB] running %0d table vectors", vecs.size());
      for (int i = 0; i < vecs.size(); i++) begin
         applyStimulus(vecs[i].din_vld, vecs[i].din, vecs[i].dout_rdy);
         #1;
         checkPair($sformatf("row%0d", i), vecs[i].exp_din_rdy, vecs[i].exp_vld,
                   vecs[i].exp_last, vecs[i].exp_lsb, vecs[i].exp_msb, vecs[i].exp_vld);
         @(posedge clk);
         #1;
      end

      // Reset after two slices of A5 (01_01_10_10 lsb order) with 3C pending.
      applyStimulus(1'b1, 8'hA5, 1'b1);
      @(posedge clk);
      #1;
      applyStimulus(1'b1, 8'h3C, 1'b1);
      #1;
      checkPair("mid s0", 1'b1, 1'b1, 1'b0, 2'b01, 2'b10, 1'b1);
      @(posedge clk);
      #1;
      applyStimulus(1'b0, 8'h00, 1'b1);
      #1;
      checkPair("mid s1", 1'b0, 1'b1, 1'b0, 2'b01, 2'b10, 1'b1);
      @(posedge clk);
      #1;
      applyStimulus(1'b0, 8'h00, 1'b0);
      #2;
      rst_n = 1'b0;
      #1;
      checkPair("mid reset", 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 1'b1);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // 1B = 00_01_10_11 must restart at slice 0 with nothing left of 3C.
      rst_lsb = '{2'b11, 2'b10, 2'b01, 2'b00};
      rst_msb = '{2'b00, 2'b01, 2'b10, 2'b11};
      applyStimulus(1'b1, 8'h1B, 1'b1);
      #1;
      checkPair("post load", 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0);
      @(posedge clk);
      #1;
      for (int k = 0; k < 4; k++) begin
         applyStimulus(1'b0, 8'h00, 1'b1);
         #1;
         checkPair($sformatf("post s%0d", k), 1'b1, 1'b1, (k == 3), rst_lsb[k], rst_msb[k], 1'b1);
         @(posedge clk);
         #1;
      end
      checkPair("post idle", 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0);

      // Single-slice instance: 4-word stream, one beat per word, all last.
      words = '{8'h11, 8'h22, 8'h33, 8'h44};
      r1_din_vld  = 1'b1;
      r1_din      = words[0];
      r1_dout_rdy = 1'b1;
      #1;
      checkOutput("r1 pre vld", 8'(r1_vld), 8'h00);
      @(posedge clk);
      #1;
      for (int k = 0; k < 4; k++) begin
         r1_din_vld = (k < 3);
         r1_din     = (k < 3) ? words[k + 1] : 8'h00;
         #1;
         checkOutput($sformatf("r1 w%0d vld", k), 8'(r1_vld), 8'h01);
         checkOutput($sformatf("r1 w%0d last", k), 8'(r1_last), 8'h01);
         checkOutput($sformatf("r1 w%0d dout", k), r1_dout, words[k]);
         checkOutput($sformatf("r1 w%0d din_rdy", k), 8'(r1_din_rdy), 8'h01);
         @(posedge clk);
         #1;
      end
      checkOutput("r1 idle vld", 8'(r1_vld), 8'h00);
      checkOutput("r1 idle last", 8'(r1_last), 8'h00);

      $display("End of test - %0d assertions evaluated, %0d failures", numChecks, numFails);
      $finish;
   end

endmodule
